// File: rtl/intr_ack_seq.sv
// CPU-side interrupt acknowledge sequencer: owns INTE (with the EI delay), runs the
// INTA read cycle at an instruction boundary and decodes the returned RST opcode.
module intr_ack_seq #(
    parameter int RD_WAIT = 1,
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_intr,
    input  logic [7:0]  cpu_inst,
    output logic        cpu_inte,
    output logic        cpu_inta,
    output logic        cpu_rd,
    input  logic        instr_boundary,
    input  logic        ei_req,
    input  logic        di_req,
    output logic        ack_busy,
    output logic        vec_valid,
    output logic [15:0] vec_addr,
    output logic        vec_err
);

    localparam logic [7:0] RDW = 8'(RD_WAIT);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACK, REL} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  op_q, op_d;
    logic        to_q, to_d;
    logic        inte_q, inte_d;
    logic        eip_q, eip_d;
    logic        inta_q, inta_d;
    logic        vv_q, vv_d;
    logic        ve_q, ve_d;
    logic [15:0] addr_q, addr_d;
    logic        accept;
    logic        is_rst;

    // Acceptance looks at the pre-update INTE so an EI only takes effect one boundary later.
    assign accept = (state_q == IDLE) & instr_boundary & cpu_intr & inte_q;
    assign is_rst = (op_q[7:6] == 2'b11) && (op_q[2:0] == 3'b111);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            to_q    <= 1'b0;
            inte_q  <= 1'b0;
            eip_q   <= 1'b0;
            inta_q  <= 1'b0;
            vv_q    <= 1'b0;
            ve_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            to_q    <= to_d;
            inte_q  <= inte_d;
            eip_q   <= eip_d;
            inta_q  <= inta_d;
            vv_q    <= vv_d;
            ve_q    <= ve_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        to_d    = to_q;
        inte_d  = inte_q;
        eip_d   = eip_q;
        inta_d  = inta_q;
        vv_d    = 1'b0;
        ve_d    = 1'b0;
        addr_d  = addr_q;

        // INTE bookkeeping; later assignments take priority (DI over everything).
        if ((state_q == IDLE) && instr_boundary && eip_q) begin
            inte_d = 1'b1;
            eip_d  = 1'b0;
        end
        if (ei_req) eip_d = 1'b1;
        if (accept) begin
            inte_d = 1'b0;
            if (!ei_req) eip_d = 1'b0;
        end
        if (di_req) begin
            inte_d = 1'b0;
            eip_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    inta_d  = 1'b1;
                    to_d    = 1'b0;
                end
            end
            ACK: begin
                cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + 8'd1;
                if ((cnt_q >= RDW) && (cpu_inst != 8'h00)) begin
                    op_d    = cpu_inst;
                    to_d    = 1'b0;
                    inta_d  = 1'b0;
                    state_d = REL;
                end else if (cnt_q == TMO) begin
                    to_d    = 1'b1;
                    inta_d  = 1'b0;
                    state_d = REL;
                end
            end
            REL: begin
                state_d = IDLE;
                if (!to_q && is_rst) begin
                    vv_d   = 1'b1;
                    addr_d = {10'b0, op_q[5:3], 3'b000};
                end else begin
                    ve_d   = 1'b1;
                    addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_inte  = inte_q;
    assign cpu_inta  = inta_q;
    assign cpu_rd    = inta_q;
    assign ack_busy  = (state_q != IDLE);
    assign vec_valid = vv_q;
    assign vec_err   = ve_q;
    assign vec_addr  = addr_q;

endmodule
